// File: rtl/ahbl_excl_monitor.sv
// AHB-Lite global exclusive monitor: one reservation slot per master ID, squashes
// failed exclusive stores towards the slave and completes them locally.
module ahbl_excl_slot #(
  parameter int W_KEY = 30
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             set,
  input  logic             clr_sel,
  input  logic             clr_key,
  input  logic [W_KEY-1:0] dph_key,
  input  logic [W_KEY-1:0] cmp_key,
  output logic             valid,
  output logic             hit
);
  logic [W_KEY-1:0] key;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      valid <= 1'b0;
      key   <= '0;
    end else if (set) begin
      valid <= 1'b1;
      key   <= dph_key;
    end else if (clr_sel || (clr_key && key == dph_key)) begin
      valid <= 1'b0;
    end
  end

  assign hit = valid && (key == cmp_key);
endmodule

module ahbl_excl_monitor #(
  parameter int N_MASTERS    = 2,
  parameter int W_ADDR       = 32,
  parameter int GRANULE_BITS = 2
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 src_hready,
  input  logic [1:0]           src_htrans,
  input  logic [W_ADDR-1:0]    src_haddr,
  input  logic                 src_hwrite,
  input  logic                 src_hexcl,
  input  logic [7:0]           src_hmaster,
  output logic                 src_hready_resp,
  output logic                 src_hresp,
  output logic                 src_hexokay,
  output logic [1:0]           dst_htrans,
  output logic                 dst_hready,
  input  logic                 dst_hready_resp,
  input  logic                 dst_hresp,
  output logic [N_MASTERS-1:0] res_valid
);
  localparam int W_KEY = W_ADDR - GRANULE_BITS;

  typedef struct packed {
    logic             valid;
    logic             excl;
    logic             write;
    logic             squash;
    logic [7:0]       id;
    logic [W_KEY-1:0] key;
  } dph_t;

  dph_t dph;
  logic [N_MASTERS-1:0] id_sel, dph_sel, slot_hit;
  logic [W_KEY-1:0]     key;
  logic accepted, hit, squash_a, dph_id_ok, done;
  logic upd_set, upd_clr_own, upd_clr_key;

  // One-hot selects double as the ID range check: an out-of-range ID selects nothing.
  assign accepted = src_hready && src_htrans[1];
  assign key      = src_haddr[W_ADDR-1:GRANULE_BITS];
  assign hit      = |(id_sel & slot_hit);
  assign squash_a = accepted && src_hexcl && src_hwrite && !hit;

  assign dst_htrans = squash_a ? 2'b00 : src_htrans;
  assign dst_hready = src_hready;

  always_ff @(posedge clk or posedge rst) begin
    if (rst)
      dph <= '0;
    else if (src_hready)
      dph <= '{valid: accepted, excl: src_hexcl, write: src_hwrite,
               squash: squash_a, id: src_hmaster, key: key};
  end

  assign dph_id_ok       = |dph_sel;
  assign src_hready_resp = dph.squash ? 1'b1 : dst_hready_resp;
  assign src_hresp       = dph.squash ? 1'b0 : dst_hresp;
  assign src_hexokay     = dph.valid && dph.excl && !dph.squash && dph_id_ok && !dst_hresp;

  // Completion is the last dphase cycle, so an ERROR is judged on its second beat.
  assign done        = dph.valid && src_hready_resp;
  assign upd_set     = done && dph.excl && !dph.write && !src_hresp;
  assign upd_clr_key = done && dph.write && (!dph.excl || src_hexokay);
  assign upd_clr_own = done && dph.write && dph.excl && !src_hexokay;

  for (genvar i = 0; i < N_MASTERS; i++) begin : g_slot
    assign id_sel[i]  = (src_hmaster == 8'(i));
    assign dph_sel[i] = (dph.id == 8'(i));

    ahbl_excl_slot #(.W_KEY(W_KEY)) u_slot (
      .clk     (clk),
      .rst     (rst),
      .set     (upd_set && dph_sel[i]),
      .clr_sel (upd_clr_own && dph_sel[i]),
      .clr_key (upd_clr_key),
      .dph_key (dph.key),
      .cmp_key (key),
      .valid   (res_valid[i]),
      .hit     (slot_hit[i])
    );
  end
endmodule

// File: tb/tb_ahbl_excl_monitor.sv
// Directed bench for ahbl_excl_monitor: stimulus queues expected dphase responses,
// a negedge monitor pops and compares them at each dphase completion.
module tb_ahbl_excl_monitor;
  localparam int N = 2;
  localparam int W = 32;

  logic         clk = 1'b0;
  logic         rst;
  logic         src_hready;
  logic [1:0]   src_htrans;
  logic [W-1:0] src_haddr;
  logic         src_hwrite, src_hexcl;
  logic [7:0]   src_hmaster;
  logic         src_hready_resp, src_hresp, src_hexokay;
  logic [1:0]   dst_htrans;
  logic         dst_hready, dst_hready_resp, dst_hresp;
  logic [N-1:0] res_valid;

  ahbl_excl_monitor #(.N_MASTERS(N), .W_ADDR(W), .GRANULE_BITS(2)) dut (
    .clk(clk), .rst(rst),
    .src_hready(src_hready), .src_htrans(src_htrans), .src_haddr(src_haddr),
    .src_hwrite(src_hwrite), .src_hexcl(src_hexcl), .src_hmaster(src_hmaster),
    .src_hready_resp(src_hready_resp), .src_hresp(src_hresp), .src_hexokay(src_hexokay),
    .dst_htrans(dst_htrans), .dst_hready(dst_hready),
    .dst_hready_resp(dst_hready_resp), .dst_hresp(dst_hresp),
    .res_valid(res_valid)
  );

  always #5 clk = ~clk;

  typedef struct {
    string nm;
    logic  ok;
    logic  resp;
  } exp_t;

  exp_t sbq[$];
  int   n_run = 0;
  int   n_fail = 0;
  logic pending;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_run++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  // Tracks an open dphase from the driven bus inputs only.
  always @(posedge clk or posedge rst) begin
    if (rst) pending <= 1'b0;
    else if (src_hready) pending <= src_htrans[1];
  end

  always @(negedge clk) begin
    if (!rst && pending && src_hready_resp) begin
      if (sbq.size() == 0) begin
        n_run++;
        n_fail++;
        $display("FAIL unexpected_completion: got completion expected none");
      end else begin
        exp_t e;
        e = sbq.pop_front();
        chk({e.nm, "_hexokay"}, 32'(src_hexokay), 32'(e.ok));
        chk({e.nm, "_hresp"}, 32'(src_hresp), 32'(e.resp));
      end
    end
  end

  // One transfer: aphase, then dphase (two-cycle ERROR if err), ending just after completion.
  task automatic xfer(input string nm, input logic [7:0] id, input logic [31:0] addr,
                      input logic wr, input logic ex, input logic err,
                      input logic sq, input logic ok, input logic [1:0] rv);
    src_hready = 1'b1; src_htrans = 2'b10; src_haddr = addr;
    src_hwrite = wr; src_hexcl = ex; src_hmaster = id;
    #1 chk({nm, "_htrans"}, 32'(dst_htrans), sq ? 32'h0 : 32'h2);
    sbq.push_back('{nm, ok, err && !sq});
    @(posedge clk); #1;
    src_htrans = 2'b00; src_hwrite = 1'b0; src_hexcl = 1'b0;
    if (sq) begin
      dst_hready_resp = 1'b0;
    end else if (err) begin
      dst_hready_resp = 1'b0; dst_hresp = 1'b1; src_hready = 1'b0;
      #1 chk({nm, "_hexokay_err1"}, 32'(src_hexokay), 32'h0);
      @(posedge clk); #1;
      dst_hready_resp = 1'b1; src_hready = 1'b1;
    end
    @(posedge clk); #1;
    dst_hready_resp = 1'b1; dst_hresp = 1'b0;
    chk({nm, "_res_valid"}, 32'(res_valid), 32'(rv));
  endtask

  initial begin
    #100000;
    n_fail++;
    $display("FAIL watchdog: got timeout expected finish");
    $display("[TB] %0d tests run, %0d failed", n_run, n_fail);
    $finish;
  end

  initial begin
    rst = 1'b1; src_hready = 1'b1; src_htrans = 2'b00; src_haddr = '0;
    src_hwrite = 1'b0; src_hexcl = 1'b0; src_hmaster = 8'd0;
    dst_hready_resp = 1'b1; dst_hresp = 1'b0;
    #1;
    chk("rst_res_valid", 32'(res_valid), 32'h0);
    chk("rst_hexokay", 32'(src_hexokay), 32'h0);
    chk("rst_hready_resp", 32'(src_hready_resp), 32'h1);
    repeat (2) @(posedge clk);
    #1 rst = 1'b0;
    @(posedge clk); #1;

    //   name        id    addr      wr ex err sq ok  rv
    xfer("m0_rd",    0, 32'h100, 0, 1, 0, 0, 1, 2'b01);
    xfer("m0_wr",    0, 32'h100, 1, 1, 0, 0, 1, 2'b00);
    xfer("m1_wr_nr", 1, 32'h200, 1, 1, 0, 1, 0, 2'b00);

    xfer("m0_rd2",   0, 32'h100, 0, 1, 0, 0, 1, 2'b01);
    xfer("m1_plain", 1, 32'h102, 1, 0, 0, 0, 0, 2'b00);
    xfer("m0_wr_sq", 0, 32'h100, 1, 1, 0, 1, 0, 2'b00);

    xfer("m0_rd3",   0, 32'h100, 0, 1, 0, 0, 1, 2'b01);
    xfer("m1_rd3",   1, 32'h100, 0, 1, 0, 0, 1, 2'b11);
    xfer("m0_wr3",   0, 32'h100, 1, 1, 0, 0, 1, 2'b00);
    xfer("m1_wr3",   1, 32'h100, 1, 1, 0, 1, 0, 2'b00);

    xfer("m0_rd_err", 0, 32'h300, 0, 1, 1, 0, 0, 2'b00);
    xfer("bad_wr",    5, 32'h100, 1, 1, 0, 1, 0, 2'b00);
    xfer("bad_rd",    5, 32'h100, 0, 1, 0, 0, 0, 2'b00);

    // Non-exclusive reads keep reservations; a newer excl read replaces the old one.
    xfer("m0_rd4",   0, 32'h100, 0, 1, 0, 0, 1, 2'b01);
    xfer("m1_nrd",   1, 32'h100, 0, 0, 0, 0, 0, 2'b01);
    xfer("m0_rd5",   0, 32'h200, 0, 1, 0, 0, 1, 2'b01);
    xfer("m0_wr5",   0, 32'h100, 1, 1, 0, 1, 0, 2'b00);

    // A failed excl write clears only its own slot.
    xfer("m0_rd6",   0, 32'h100, 0, 1, 0, 0, 1, 2'b01);
    xfer("m1_rd6",   1, 32'h100, 0, 1, 0, 0, 1, 2'b11);
    xfer("m1_wr6",   1, 32'h104, 1, 1, 0, 1, 0, 2'b01);
    xfer("m1_rd7",   1, 32'h100, 0, 1, 0, 0, 1, 2'b11);

    // Reset asserted while a passing excl write sits in a stalled dphase.
    src_hready = 1'b1; src_htrans = 2'b10; src_haddr = 32'h100;
    src_hwrite = 1'b1; src_hexcl = 1'b1; src_hmaster = 8'd0;
    #1 chk("mid_htrans", 32'(dst_htrans), 32'h2);
    @(posedge clk); #1;
    src_htrans = 2'b00; src_hwrite = 1'b0; src_hexcl = 1'b0;
    dst_hready_resp = 1'b0; src_hready = 1'b0;
    #1 chk("mid_hexokay_pre", 32'(src_hexokay), 32'h1);
    chk("mid_res_valid_pre", 32'(res_valid), 32'h3);
    rst = 1'b1;
    #1 chk("mid_res_valid_rst", 32'(res_valid), 32'h0);
    chk("mid_hexokay_rst", 32'(src_hexokay), 32'h0);
    chk("mid_hready_resp_rst", 32'(src_hready_resp), 32'h0);
    @(posedge clk); #1;
    rst = 1'b0; dst_hready_resp = 1'b1; src_hready = 1'b1;
    @(posedge clk); #1;
    xfer("post_rst_wr", 0, 32'h100, 1, 1, 0, 1, 0, 2'b00);

    repeat (2) @(posedge clk);
    #1 chk("sb_empty", 32'(sbq.size()), 32'h0);
    $display("[TB] %0d tests run, %0d failed", n_run, n_fail);
    $finish;
  end
endmodule
